// File: rtl/jtdc_bus_pkg.sv
// Shared constants for the TDC bus register block: address map, FIFOSTAT layout, CMD bits.
// No logic; pure constants plus a FIFOSTAT packing helper.
// Imported by jtdc_bus_regs and its bench.
package jtdc_bus_pkg;

    localparam logic [15:0] ADDR_STATUS   = 16'h0000;
    localparam logic [15:0] ADDR_CONTROL  = 16'h0004;
    localparam logic [15:0] ADDR_SCRATCH  = 16'h0008;
    localparam logic [15:0] ADDR_FIFOSTAT = 16'h000C;
    localparam logic [15:0] ADDR_FIFODATA = 16'h0010;
    localparam logic [15:0] ADDR_EVTCNT   = 16'h0014;
    localparam logic [15:0] ADDR_CMD      = 16'h0018;
    localparam logic [15:0] ADDR_DROPCNT  = 16'h001C;

    localparam int FSTAT_OVERFLOW  = 31;
    localparam int FSTAT_UNDERFLOW = 30;
    localparam int FSTAT_FULL      = 17;
    localparam int FSTAT_EMPTY     = 16;

    localparam int CMD_CLEAR = 0;
    localparam int CMD_FLUSH = 1;

    function automatic logic [31:0] pack_fifostat(input logic ovf, input logic unf,
                                                  input logic full, input logic empty,
                                                  input logic [15:0] level);
        logic [31:0] w;
        w                  = 32'h0;
        w[FSTAT_OVERFLOW]  = ovf;
        w[FSTAT_UNDERFLOW] = unf;
        w[FSTAT_FULL]      = full;
        w[FSTAT_EMPTY]     = empty;
        w[15:0]            = level;
        return w;
    endfunction

endpackage

// File: rtl/jtdc_bus_regs_if.sv
// Internal register bus: single-cycle read/write strobes with shared address.
// Read data returns one cycle after the read strobe, qualified by rd_valid.
// No backpressure: the slave accepts every strobe.
interface jtdc_bus_regs_if;
    logic        writesignal;
    logic        readsignal;
    logic [15:0] addressbus;
    logic [31:0] databus_in;
    logic [31:0] databus_out;
    logic        rd_valid;

    modport master (output writesignal, readsignal, addressbus, databus_in,
                    input  databus_out, rd_valid);
    modport slave  (input  writesignal, readsignal, addressbus, databus_in,
                    output databus_out, rd_valid);
endinterface

// File: rtl/jtdc_sync_fifo.sv
// Single-clock FIFO with registered-output RAM and an occupancy level.
// Pop data appears on rd_data the cycle after pop; level/full/empty update the cycle after push/pop.
// No internal protection: caller only pushes when !full (or popping) and pops when !empty.
module jtdc_sync_fifo #(
    parameter int DW = 32,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   level_q;

    // RAM write port; unreset storage so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end

    // Registered RAM read; old contents win when push and pop hit the same slot at full
    always_ff @(posedge clk) begin
        if (rst)      rd_data <= '0;
        else if (pop) rd_data <= mem[rptr];
    end

    // Pointer and occupancy tracking; flush simply rewinds everything
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign level = level_q;
    assign full  = level_q[AW];  // level never exceeds 2**AW, so the MSB alone means full
    assign empty = (level_q == '0);
endmodule

// File: rtl/jtdc_bus_regs.sv
// TDC register file + event FIFO on the internal bus; define JTDC_BUS_DROPCNT_EN to build DROPCNT.
// Reads return one cycle after the strobe; writes land on the next edge.
// Events have no backpressure: words arriving while the FIFO is full are dropped and flagged.
module jtdc_bus_regs
    import jtdc_bus_pkg::*;
#(
    parameter int          FIFO_DEPTH_LOG2 = 9,
    parameter logic [31:0] CTRL_RESET      = 32'h0000_0000
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic [31:0]    statusregister,
    jtdc_bus_regs_if.slave bus,
    input  logic           evt_valid,
    input  logic [31:0]    evt_data,
    output logic [31:0]    ctrl_out,
    output logic           fifo_nempty
);
    localparam int LW = FIFO_DEPTH_LOG2 + 1;

    logic [31:0]   ctrl_q, scratch_q, evtcnt_q, dropcnt_rd, rd_q, rd_mux;
    logic          ovf_q, unf_q, rd_valid_q, rd_from_fifo_q;
    logic [31:0]   fifo_rd_data;
    logic [LW-1:0] fifo_level;
    logic          fifo_full, fifo_empty;
    logic          wr_cmd, cmd_clear, cmd_flush, cmd_kill;
    logic          pop_req, pop, push, drop;

    assign wr_cmd    = bus.writesignal && (bus.addressbus == ADDR_CMD);
    assign cmd_clear = wr_cmd && bus.databus_in[CMD_CLEAR];
    assign cmd_flush = wr_cmd && bus.databus_in[CMD_FLUSH];
    assign cmd_kill  = cmd_clear || cmd_flush;   // an event racing a CMD is discarded uncounted
    assign pop_req   = bus.readsignal && (bus.addressbus == ADDR_FIFODATA);
    assign pop       = pop_req && !fifo_empty;
    assign push      = evt_valid && !cmd_kill && (!fifo_full || pop);
    assign drop      = evt_valid && !cmd_kill && fifo_full && !pop;

    jtdc_sync_fifo #(.DW(32), .AW(FIFO_DEPTH_LOG2)) u_fifo (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .push      (push),
        .push_data (evt_data),
        .pop       (pop),
        .flush     (cmd_flush),
        .rd_data   (fifo_rd_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // CONTROL and SCRATCH writable registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ctrl_q    <= CTRL_RESET;
            scratch_q <= 32'h0;
        end else if (bus.writesignal) begin
            if (bus.addressbus == ADDR_CONTROL) ctrl_q    <= bus.databus_in;
            if (bus.addressbus == ADDR_SCRATCH) scratch_q <= bus.databus_in;
        end
    end

    // Accepted-event counter and sticky FIFO error flags, cleared by CMD bit0
    always_ff @(posedge sys_clk) begin
        if (sys_rst || cmd_clear) begin
            evtcnt_q <= 32'h0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (push)                  evtcnt_q <= evtcnt_q + 32'd1;
            if (drop)                  ovf_q    <= 1'b1;
            if (pop_req && fifo_empty) unf_q    <= 1'b1;
        end
    end

`ifdef JTDC_BUS_DROPCNT_EN
    logic [31:0] dropcnt_q;

    // Saturating count of events lost to a full FIFO
    always_ff @(posedge sys_clk) begin
        if (sys_rst || cmd_clear)              dropcnt_q <= 32'h0;
        else if (drop && dropcnt_q != '1)      dropcnt_q <= dropcnt_q + 32'd1;
    end
    assign dropcnt_rd = dropcnt_q;
`else
    assign dropcnt_rd = 32'h0;
`endif

    // Read decode from pre-write register values; FIFODATA is sourced from the FIFO output register
    always_comb begin
        rd_mux = 32'h0;
        case (bus.addressbus)
            ADDR_STATUS:   rd_mux = statusregister;
            ADDR_CONTROL:  rd_mux = ctrl_q;
            ADDR_SCRATCH:  rd_mux = scratch_q;
            ADDR_FIFOSTAT: rd_mux = pack_fifostat(ovf_q, unf_q, fifo_full, fifo_empty,
                                                  16'(fifo_level));
            ADDR_EVTCNT:   rd_mux = evtcnt_q;
            ADDR_DROPCNT:  rd_mux = dropcnt_rd;
            default:       rd_mux = 32'h0;
        endcase
    end

    // Read response register: held until the next read strobe
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_valid_q     <= 1'b0;
            rd_q           <= 32'h0;
            rd_from_fifo_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.readsignal;
            if (bus.readsignal) begin
                rd_q           <= rd_mux;
                rd_from_fifo_q <= pop;
            end
        end
    end

    assign bus.databus_out = rd_from_fifo_q ? fifo_rd_data : rd_q;
    // Masking with reset cancels a read whose response would land during reset
    assign bus.rd_valid    = rd_valid_q && !sys_rst;
    assign ctrl_out        = ctrl_q;
    assign fifo_nempty     = !fifo_empty;
endmodule

// File: tb/tb_jtdc_bus_regs.sv
// Directed bench for jtdc_bus_regs: register access, FIFO push/pop, overflow, CMD and reset.
// Inputs change 1 time unit after the rising edge; outputs sampled there as well.
// Expected values are hand-computed constants.
module tb_jtdc_bus_regs;
    import jtdc_bus_pkg::*;

    localparam logic [31:0] CTRL_INIT = 32'h1234_0005;
`ifdef JTDC_BUS_DROPCNT_EN
    localparam logic [31:0] DROP_EXP = 32'd5;
`else
    localparam logic [31:0] DROP_EXP = 32'd0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] statusregister;
    logic        evt_valid;
    logic [31:0] evt_data;
    logic [31:0] ctrl_out;
    logic        fifo_nempty;
    logic [31:0] rdat;
    int          total = 0;
    int          bad   = 0;

    jtdc_bus_regs_if bus_if ();

    jtdc_bus_regs #(.FIFO_DEPTH_LOG2(9), .CTRL_RESET(CTRL_INIT)) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .statusregister (statusregister),
        .bus            (bus_if),
        .evt_valid      (evt_valid),
        .evt_data       (evt_data),
        .ctrl_out       (ctrl_out),
        .fifo_nempty    (fifo_nempty)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        bus_if.writesignal = 1'b1;
        bus_if.addressbus  = a;
        bus_if.databus_in  = d;
        cyc();
        bus_if.writesignal = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
        bus_if.readsignal = 1'b1;
        bus_if.addressbus = a;
        cyc();
        bus_if.readsignal = 1'b0;
        check({tag, "_vld"}, 32'(bus_if.rd_valid), 32'd1);
        check(tag, bus_if.databus_out, exp);
    endtask

    task automatic push_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            evt_valid = 1'b1;
            evt_data  = base + 32'(i);
            cyc();
        end
        evt_valid = 1'b0;
    endtask

    initial begin
        statusregister     = 32'h0000_0101;
        bus_if.writesignal = 1'b0;
        bus_if.readsignal  = 1'b0;
        bus_if.addressbus  = 16'h0;
        bus_if.databus_in  = 32'h0;
        evt_valid          = 1'b0;
        evt_data           = 32'h0;

        // Reset with strobes and events active: all must be ignored
        sys_rst            = 1'b1;
        bus_if.writesignal = 1'b1;
        bus_if.readsignal  = 1'b1;
        bus_if.addressbus  = ADDR_CONTROL;
        bus_if.databus_in  = 32'hFFFF_FFFF;
        evt_valid          = 1'b1;
        repeat (3) cyc();
        check("rst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
        check("rst_ctrl", ctrl_out, CTRL_INIT);
        check("rst_nempty", 32'(fifo_nempty), 32'd0);
        check("rst_dout", bus_if.databus_out, 32'h0);
        bus_if.writesignal = 1'b0;
        bus_if.readsignal  = 1'b0;
        evt_valid          = 1'b0;
        sys_rst            = 1'b0;
        cyc();
        rd_chk("init_ctrl", ADDR_CONTROL, CTRL_INIT);
        rd_chk("init_fstat", ADDR_FIFOSTAT, 32'h0001_0000);
        rd_chk("init_evtcnt", ADDR_EVTCNT, 32'h0);

        // Scratch write then read: one-cycle latency, single-cycle pulse
        wr(ADDR_SCRATCH, 32'hA5A5_5A5A);
        bus_if.readsignal = 1'b1;
        bus_if.addressbus = ADDR_SCRATCH;
        #1;
        check("lat_early_vld", 32'(bus_if.rd_valid), 32'd0);
        @(posedge sys_clk);
        #1;
        bus_if.readsignal = 1'b0;
        check("lat_vld", 32'(bus_if.rd_valid), 32'd1);
        check("scratch", bus_if.databus_out, 32'hA5A5_5A5A);
        cyc();
        check("vld_pulse", 32'(bus_if.rd_valid), 32'd0);
        check("dout_hold", bus_if.databus_out, 32'hA5A5_5A5A);
        rd_chk("status", ADDR_STATUS, 32'h0000_0101);

        // CONTROL drives ctrl_out at N+1; RO and unmapped behaviour
        wr(ADDR_CONTROL, 32'hDEAD_BEEF);
        check("ctrl_out", ctrl_out, 32'hDEAD_BEEF);
        wr(ADDR_STATUS, 32'hFFFF_FFFF);
        rd_chk("status_ro", ADDR_STATUS, 32'h0000_0101);
        rd_chk("unmapped", 16'h0020, 32'h0);
        rd_chk("cmd_rd", ADDR_CMD, 32'h0);

        // Simultaneous write and read returns the pre-write value
        bus_if.writesignal = 1'b1;
        bus_if.readsignal  = 1'b1;
        bus_if.addressbus  = ADDR_SCRATCH;
        bus_if.databus_in  = 32'h1111_2222;
        cyc();
        bus_if.writesignal = 1'b0;
        bus_if.readsignal  = 1'b0;
        check("wr_rd_old", bus_if.databus_out, 32'hA5A5_5A5A);
        rd_chk("wr_rd_new", ADDR_SCRATCH, 32'h1111_2222);

        // Three events, four pops: last pop underflows
        push_words(1, 32'h11);
        push_words(1, 32'h22);
        push_words(1, 32'h33);
        check("nempty3", 32'(fifo_nempty), 32'd1);
        rd_chk("fstat3", ADDR_FIFOSTAT, 32'h0000_0003);
        rd_chk("pop0", ADDR_FIFODATA, 32'h11);
        rd_chk("pop1", ADDR_FIFODATA, 32'h22);
        rd_chk("pop2", ADDR_FIFODATA, 32'h33);
        rd_chk("pop_empty", ADDR_FIFODATA, 32'h0);
        rd_chk("fstat_unf", ADDR_FIFOSTAT, 32'h4001_0000);
        rd_chk("evtcnt3", ADDR_EVTCNT, 32'd3);

        // Clear counters/flags
        wr(ADDR_CMD, 32'h1);
        rd_chk("fstat_clr", ADDR_FIFOSTAT, 32'h0001_0000);
        rd_chk("evtcnt_clr", ADDR_EVTCNT, 32'h0);

        // Overfill by five
        push_words(517, 32'h1000);
        rd_chk("fstat_full", ADDR_FIFOSTAT, 32'h8002_0200);
        rd_chk("dropcnt", ADDR_DROPCNT, DROP_EXP);
        rd_chk("evtcnt_full", ADDR_EVTCNT, 32'd512);

        // Push and pop together at full: nothing dropped
        bus_if.readsignal = 1'b1;
        bus_if.addressbus = ADDR_FIFODATA;
        evt_valid         = 1'b1;
        evt_data          = 32'hBEEF;
        cyc();
        bus_if.readsignal = 1'b0;
        evt_valid         = 1'b0;
        check("full_pop", bus_if.databus_out, 32'h1000);
        rd_chk("fstat_pp", ADDR_FIFOSTAT, 32'h8002_0200);
        rd_chk("dropcnt_pp", ADDR_DROPCNT, DROP_EXP);
        rd_chk("evtcnt_pp", ADDR_EVTCNT, 32'd513);

        // Flush+clear with a racing event
        evt_valid = 1'b1;
        evt_data  = 32'h5555;
        wr(ADDR_CMD, 32'h3);
        evt_valid = 1'b0;
        check("cmd_nempty", 32'(fifo_nempty), 32'd0);
        rd_chk("cmd_fstat", ADDR_FIFOSTAT, 32'h0001_0000);
        rd_chk("cmd_evtcnt", ADDR_EVTCNT, 32'h0);
        rd_chk("cmd_dropcnt", ADDR_DROPCNT, 32'h0);
        push_words(1, 32'h77);
        push_words(1, 32'h88);
        rd_chk("post_flush0", ADDR_FIFODATA, 32'h77);
        rd_chk("post_flush1", ADDR_FIFODATA, 32'h88);

        // Reset the cycle after a read strobe
        wr(ADDR_CONTROL, 32'h55);
        wr(ADDR_SCRATCH, 32'h66);
        push_words(1, 32'h99);
        check("pre_rst_nempty", 32'(fifo_nempty), 32'd1);
        bus_if.readsignal = 1'b1;
        bus_if.addressbus = ADDR_SCRATCH;
        cyc();
        bus_if.readsignal = 1'b0;
        sys_rst           = 1'b1;
        #1;
        check("rst_cancel_vld", 32'(bus_if.rd_valid), 32'd0);
        cyc();
        check("rst2_vld", 32'(bus_if.rd_valid), 32'd0);
        check("rst2_ctrl", ctrl_out, CTRL_INIT);
        check("rst2_nempty", 32'(fifo_nempty), 32'd0);
        check("rst2_dout", bus_if.databus_out, 32'h0);
        sys_rst = 1'b0;
        cyc();
        rd_chk("rst2_scratch", ADDR_SCRATCH, 32'h0);
        rd_chk("rst2_fstat", ADDR_FIFOSTAT, 32'h0001_0000);
        rd_chk("rst2_evtcnt", ADDR_EVTCNT, 32'h0);
        rd_chk("rst2_pop", ADDR_FIFODATA, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
